// File: rtl/rx_config_sequencer.sv
// Shadow/live MAC-IP configuration table with a quiescence-gated atomic commit.
// Rx is held off while the live table is rewritten so the scanner never sees a mixed set.
module rx_config_sequencer #(
    parameter int unsigned aw            = 4,
    parameter int unsigned quiet_cycles  = 16,
    parameter int unsigned drain_timeout = 4095
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [aw-1:0] host_a,
    input  logic [7:0]    host_d,
    input  logic          host_we,
    input  logic          host_commit,
    input  logic          host_rx_en,
    input  logic          eth_in_s,
    input  logic          odata_s,
    input  logic [aw-1:0] ip_a,
    output logic [7:0]    ip_d,
    output logic          enable_rx,
    output logic          cfg_busy,
    output logic          cfg_done,
    output logic          cfg_reject,
    output logic          cfg_err
);
    localparam int unsigned depth  = 1 << aw;
    localparam int unsigned cw     = aw + 1;
    localparam int unsigned qw     = $clog2(quiet_cycles + 1);
    localparam int unsigned dw_min = $clog2(drain_timeout + 1);
    localparam int unsigned dw     = (dw_min > 12) ? dw_min : 12;

    localparam logic [qw-1:0] quiet_max = qw'(quiet_cycles);
    localparam logic [dw-1:0] drain_max = dw'(drain_timeout);
    localparam logic [cw-1:0] copy_last = cw'(depth);

    typedef enum logic [1:0] {StIdle, StDrain, StCopy} state_e;

    state_e        state_q;
    logic [qw-1:0] quiet_q;
    logic [dw-1:0] drain_q;
    logic [cw-1:0] copy_q;
    logic [7:0]    rd_q;

    logic [7:0] shadow [depth];
    logic [7:0] live   [depth];

    logic [qw-1:0] quiet_nx;
    logic [dw-1:0] drain_nx;
    logic          quiet_hit;
    logic          timeout_hit;
    logic          shadow_we;
    logic          live_we;
    logic [aw-1:0] live_wa;

    always_comb begin
        quiet_nx = '0;
        if (!(eth_in_s || odata_s)) begin
            quiet_nx = (quiet_q == quiet_max) ? quiet_q : quiet_q + 1'b1;
        end
        drain_nx    = drain_q + 1'b1;
        quiet_hit   = (quiet_nx == quiet_max);
        timeout_hit = (drain_timeout != 0) && (drain_nx == drain_max);
        shadow_we   = host_we && (state_q == StIdle);
        // The shadow read runs one cycle ahead, so the write lags the copy address by one.
        live_we     = (state_q == StCopy) && (copy_q != '0);
        live_wa     = copy_q[aw-1:0] - 1'b1;
    end

    // Table storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (shadow_we) begin
            shadow[host_a] <= host_d;
        end
        if (live_we) begin
            live[live_wa] <= rd_q;
        end
        if ((state_q == StCopy) && !copy_q[aw]) begin
            rd_q <= shadow[copy_q[aw-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            quiet_q    <= '0;
            drain_q    <= '0;
            copy_q     <= '0;
            ip_d       <= '0;
            enable_rx  <= 1'b0;
            cfg_busy   <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_reject <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            ip_d       <= live[ip_a];
            enable_rx  <= host_rx_en && (state_q == StIdle);
            cfg_done   <= 1'b0;
            cfg_reject <= (host_we || host_commit) && (state_q != StIdle);
            unique case (state_q)
                StIdle: begin
                    if (host_commit) begin
                        state_q  <= StDrain;
                        quiet_q  <= '0;
                        drain_q  <= '0;
                        cfg_err  <= 1'b0;
                        cfg_busy <= 1'b1;
                    end
                end
                StDrain: begin
                    quiet_q <= quiet_nx;
                    drain_q <= drain_nx;
                    // Quiescence takes priority over a timeout landing on the same cycle.
                    if (quiet_hit) begin
                        state_q <= StCopy;
                        copy_q  <= '0;
                    end else if (timeout_hit) begin
                        state_q  <= StIdle;
                        cfg_err  <= 1'b1;
                        cfg_busy <= 1'b0;
                    end
                end
                StCopy: begin
                    copy_q <= copy_q + 1'b1;
                    if (copy_q == copy_last) begin
                        state_q  <= StIdle;
                        cfg_done <= 1'b1;
                        cfg_busy <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_rx_config_sequencer.sv
// Bench for rx_config_sequencer: directed scenarios plus randomized commits against a table model.
// Instance 0 uses the default drain timeout, instance 1 a short timeout of 50 cycles.
module tb_rx_config_sequencer;
    localparam int QUIET    = 16;
    localparam int TO0      = 4095;
    localparam int TO1      = 50;
    localparam int COPY_LEN = 17;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] host_a = '0;
    logic [7:0] host_d = '0;
    logic       we0 = 1'b0, we1 = 1'b0;
    logic       commit0 = 1'b0, commit1 = 1'b0;
    logic       host_rx_en = 1'b1;
    logic       eth_in_s = 1'b0, odata_s = 1'b0;
    logic [3:0] ip_a = '0;
    logic [7:0] ipd0, ipd1;
    logic [1:0] en_w, busy_w, done_w, rej_w, err_w;

    int total = 0;
    int bad   = 0;

    logic [7:0] sh   [2][16];
    logic [7:0] live [2][16];
    bit         live_ok [2];
    bit         eth_t [1:400];
    bit         od_t  [1:400];

    always #5 clk = ~clk;

    rx_config_sequencer #(.aw(4), .quiet_cycles(QUIET), .drain_timeout(TO0)) dut0 (
        .clk(clk), .rst(rst), .host_a(host_a), .host_d(host_d), .host_we(we0),
        .host_commit(commit0), .host_rx_en(host_rx_en), .eth_in_s(eth_in_s),
        .odata_s(odata_s), .ip_a(ip_a), .ip_d(ipd0), .enable_rx(en_w[0]),
        .cfg_busy(busy_w[0]), .cfg_done(done_w[0]), .cfg_reject(rej_w[0]), .cfg_err(err_w[0])
    );

    rx_config_sequencer #(.aw(4), .quiet_cycles(QUIET), .drain_timeout(TO1)) dut1 (
        .clk(clk), .rst(rst), .host_a(host_a), .host_d(host_d), .host_we(we1),
        .host_commit(commit1), .host_rx_en(host_rx_en), .eth_in_s(eth_in_s),
        .odata_s(odata_s), .ip_a(ip_a), .ip_d(ipd1), .enable_rx(en_w[1]),
        .cfg_busy(busy_w[1]), .cfg_done(done_w[1]), .cfg_reject(rej_w[1]), .cfg_err(err_w[1])
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ipd(input int s);
        return (s == 0) ? ipd0 : ipd1;
    endfunction

    task automatic wr(input int sel, input logic [3:0] a, input logic [7:0] d);
        host_a = a;
        host_d = d;
        if (sel == 0) we0 = 1'b1; else we1 = 1'b1;
        step();
        we0 = 1'b0;
        we1 = 1'b0;
        sh[sel][a] = d;
        chk("wr_no_reject", {7'd0, rej_w[sel]}, 8'd0);
    endtask

    task automatic clear_traffic();
        for (int k = 1; k <= 400; k++) begin
            eth_t[k] = 1'b0;
            od_t[k]  = 1'b0;
        end
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) begin
            ip_a = 4'(i);
            step();
            for (int s = 0; s < 2; s++) begin
                if (live_ok[s]) chk($sformatf("rd%0d_a%0d", s, i), ipd(s), live[s][i]);
            end
        end
    endtask

    // Drive one commit on instance sel and check every cycle until it settles back to idle.
    task automatic run_commit(input int sel, input int ntraf, input int rej_commit_at,
                              input int rej_we_at, input bit simul_we);
        int  run;
        int  drain_len;
        int  last;
        int  to;
        int  ra;
        bit  timed_out;
        bit  exp_rej;
        // Drain ends once QUIET consecutive traffic-free cycles have been seen.
        run = 0;
        drain_len = 0;
        for (int k = 1; k <= 1000 && drain_len == 0; k++) begin
            if (k <= ntraf && (eth_t[k] || od_t[k])) run = 0;
            else run++;
            if (run == QUIET) drain_len = k;
        end
        to = (sel == 0) ? TO0 : TO1;
        timed_out = (to != 0) && (drain_len > to);
        last = timed_out ? to : drain_len + COPY_LEN;

        if (sel == 0) commit0 = 1'b1; else commit1 = 1'b1;
        if (simul_we) begin
            host_a = 4'd15;
            host_d = 8'h5A;
            if (sel == 0) we0 = 1'b1; else we1 = 1'b1;
            sh[sel][15] = 8'h5A;
        end
        step();
        we0 = 1'b0;
        we1 = 1'b0;

        for (int c = 1; c <= last + 1; c++) begin
            eth_in_s = (c <= ntraf) ? eth_t[c] : 1'b0;
            odata_s  = (c <= ntraf) ? od_t[c]  : 1'b0;
            if (sel == 0) commit0 = (c == rej_commit_at);
            else          commit1 = (c == rej_commit_at);
            if (c == rej_we_at) begin
                host_a = 4'd3;
                host_d = 8'hAA;
                if (sel == 0) we0 = 1'b1; else we1 = 1'b1;
            end
            ra = $urandom_range(0, 15);
            ip_a = 4'(ra);
            step();
            we0 = 1'b0;
            we1 = 1'b0;
            exp_rej = (c == rej_commit_at) || (c == rej_we_at);
            chk($sformatf("busy_c%0d", c), {7'd0, busy_w[sel]}, {7'd0, c < last});
            chk($sformatf("done_c%0d", c), {7'd0, done_w[sel]}, {7'd0, !timed_out && c == last});
            chk($sformatf("en_c%0d", c), {7'd0, en_w[sel]}, {7'd0, c > last});
            chk($sformatf("rej_c%0d", c), {7'd0, rej_w[sel]}, {7'd0, exp_rej});
            chk($sformatf("err_c%0d", c), {7'd0, err_w[sel]}, {7'd0, timed_out && c >= last});
            for (int s = 0; s < 2; s++) begin
                if (live_ok[s] && (s != sel || timed_out || c <= drain_len + 1))
                    chk($sformatf("rd_stable%0d_c%0d", s, c), ipd(s), live[s][ra]);
            end
        end
        eth_in_s = 1'b0;
        odata_s  = 1'b0;
        commit0  = 1'b0;
        commit1  = 1'b0;
        if (!timed_out) begin
            for (int i = 0; i < 16; i++) live[sel][i] = sh[sel][i];
            live_ok[sel] = 1'b1;
        end
    endtask

    task automatic reset_mid_copy();
        commit0 = 1'b1;
        step();
        commit0 = 1'b0;
        // Copy address 7 is current after QUIET + 7 edges.
        for (int c = 1; c <= QUIET + 7; c++) step();
        #2;
        rst = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("rst_mid_en%0d", s), {7'd0, en_w[s]}, 8'd0);
            chk($sformatf("rst_mid_ipd%0d", s), ipd(s), 8'd0);
            chk($sformatf("rst_mid_busy%0d", s), {7'd0, busy_w[s]}, 8'd0);
            chk($sformatf("rst_mid_done%0d", s), {7'd0, done_w[s]}, 8'd0);
            chk($sformatf("rst_mid_err%0d", s), {7'd0, err_w[s]}, 8'd0);
        end
        live_ok[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("rst_mid_done_after", {7'd0, done_w[0]}, 8'd0);
        chk("rst_mid_en_back", {7'd0, en_w[0]}, 8'd1);
        chk("rst_mid_idle", {7'd0, busy_w[0]}, 8'd0);
    endtask

    initial begin
        int n;
        int dens;
        live_ok[0] = 1'b0;
        live_ok[1] = 1'b0;
        clear_traffic();

        #12;
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("reset_en%0d", s), {7'd0, en_w[s]}, 8'd0);
            chk($sformatf("reset_ipd%0d", s), ipd(s), 8'd0);
            chk($sformatf("reset_busy%0d", s), {7'd0, busy_w[s]}, 8'd0);
            chk($sformatf("reset_done%0d", s), {7'd0, done_w[s]}, 8'd0);
            chk($sformatf("reset_rej%0d", s), {7'd0, rej_w[s]}, 8'd0);
            chk($sformatf("reset_err%0d", s), {7'd0, err_w[s]}, 8'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("en_after_reset", {7'd0, en_w[0]}, 8'd1);

        // Basic commit.
        for (int i = 0; i < 16; i++) wr(0, 4'(i), 8'(8'h10 + i));
        run_commit(0, 0, 0, 0, 1'b0);
        ip_a = 4'd5;
        step();
        chk("basic_ipd_a5", ipd0, 8'h15);
        chk("basic_en", {7'd0, en_w[0]}, 8'd1);
        for (int i = 0; i < 16; i++) wr(1, 4'(i), 8'($urandom_range(0, 255)));
        run_commit(1, 0, 0, 0, 1'b0);
        read_all();

        // Drain with traffic: eth 100 cycles then odata 2 more.
        for (int i = 0; i < 16; i++) wr(0, 4'(i), 8'($urandom_range(0, 255)));
        clear_traffic();
        for (int k = 1; k <= 100; k++) eth_t[k] = 1'b1;
        od_t[101] = 1'b1;
        od_t[102] = 1'b1;
        eth_in_s = 1'b1;
        run_commit(0, 102, 0, 0, 1'b0);
        read_all();

        // Rejected write during COPY and rejected commit during DRAIN.
        clear_traffic();
        wr(0, 4'd3, 8'h33);
        run_commit(0, 0, 3, QUIET + 5, 1'b0);
        read_all();

        // Shadow write in the same cycle as commit.
        run_commit(0, 0, 0, 0, 1'b1);
        read_all();

        // Randomized commits with random traffic.
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++)
                wr(0, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            clear_traffic();
            n = $urandom_range(0, 60);
            dens = $urandom_range(5, 40);
            for (int k = 1; k <= n; k++) begin
                eth_t[k] = ($urandom_range(0, 99) < dens);
                od_t[k]  = ($urandom_range(0, 99) < dens);
            end
            run_commit(0, n, (it % 2 == 0) ? int'($urandom_range(1, QUIET)) : 0,
                       (it % 3 == 0) ? int'($urandom_range(QUIET + 1, QUIET + COPY_LEN)) : 0,
                       1'b0);
            read_all();
        end

        // Asynchronous reset in the middle of COPY, then a clean re-commit.
        clear_traffic();
        for (int i = 0; i < 16; i++) wr(0, 4'(i), 8'($urandom_range(0, 255)));
        reset_mid_copy();
        run_commit(0, 0, 0, 0, 1'b0);
        read_all();

        // Drain timeout on the short-timeout instance; live table must not move.
        for (int i = 0; i < 16; i++) wr(1, 4'(i), 8'($urandom_range(0, 255)));
        clear_traffic();
        for (int k = 1; k <= 80; k++) eth_t[k] = 1'b1;
        eth_in_s = 1'b1;
        run_commit(1, 80, 0, 0, 1'b0);
        chk("to_err_sticky", {7'd0, err_w[1]}, 8'd1);
        read_all();
        // Quiet exactly at the timeout cycle wins over the timeout.
        clear_traffic();
        for (int k = 1; k <= TO1 - QUIET; k++) eth_t[k] = 1'b1;
        run_commit(1, TO1 - QUIET, 0, 0, 1'b0);
        read_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
